letter_scroll_ctrl: RTL

//  Buffers a short message of 4-bit letter codes and scrolls it right-to-left across a
//  4-digit multiplexed 7-seg display. Each cycle it drives one digit's code to the shared

---
 rtl/letter_scroll_ctrl.sv | 100 ++++++++++
 1 files changed

// File: rtl/letter_scroll_ctrl.sv
// letter_scroll_ctrl: buffers 4-bit letter codes and scrolls them right-to-left over a 4-digit muxed 7-seg.
// Optional SCROLL_LOOP_EN: repeat the pass continuously until stop/clear instead of returning to ARMED.
module letter_scroll_ctrl #(
    parameter int REFRESH_DIV = 100000,
    parameter int SCROLL_DIV  = 25000000,
    parameter int MSG_DEPTH   = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_valid,
    input  logic [3:0] wr_code,
    input  logic       wr_last,
    output logic       wr_ready,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    output logic       busy,
    output logic       done,
    output logic [3:0] code,
    output logic       blank,
    output logic [3:0] an
);
    localparam int LW = $clog2(MSG_DEPTH + 4);
    localparam int AW = MSG_DEPTH > 1 ? $clog2(MSG_DEPTH) : 1;
    localparam int RW = $clog2(REFRESH_DIV);
    localparam int SW = SCROLL_DIV > 1 ? $clog2(SCROLL_DIV) : 1;
    typedef enum logic [1:0] {IDLE, LOAD, ARMED, SCROLL} state_t;
    state_t        state_q;
    logic [LW-1:0] len_q, pos_q;
    logic [RW-1:0] rcnt_q;
    logic [SW-1:0] scnt_q;
    logic [1:0]    digit_q;
    logic [3:0]    msg_q [MSG_DEPTH];
    logic [3:0]    an_q, code_q;
    logic          blank_q, done_q;
    logic          wr_fire, rwrap, swrap, pass_end, show;
    logic [LW:0]   j;
    assign wr_ready = (state_q == IDLE || state_q == LOAD) && len_q < LW'(MSG_DEPTH);
    assign wr_fire  = wr_valid && wr_ready;
    assign rwrap    = rcnt_q == RW'(REFRESH_DIV - 1);
    assign swrap    = scnt_q == SW'(SCROLL_DIV - 1);
    assign pass_end = state_q == SCROLL && swrap && pos_q == len_q + LW'(3);
    // Letter index for the selected digit; the extra MSB acts as the sign for j<0
    assign j        = {1'b0, pos_q} - (LW + 1)'(digit_q);
    assign show     = state_q == SCROLL && !j[LW] && j[LW-1:0] < len_q;
    assign busy     = state_q == SCROLL;
    assign done     = done_q;
    assign code     = code_q;
    assign blank    = blank_q;
    assign an       = an_q;
    always_ff @(posedge clk)
        if (wr_fire && !clear) msg_q[len_q[AW-1:0]] <= wr_code;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            len_q   <= '0;
            pos_q   <= '0;
            rcnt_q  <= '0;
            scnt_q  <= '0;
            digit_q <= '0;
            an_q    <= 4'hF;
            code_q  <= '0;
            blank_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            rcnt_q  <= rwrap ? '0 : rcnt_q + 1'b1;
            digit_q <= rwrap ? digit_q + 2'd1 : digit_q;
            an_q    <= ~(4'b1 << digit_q);
            code_q  <= show ? msg_q[j[AW-1:0]] : 4'd0;
            blank_q <= !show;
            done_q  <= pass_end && !clear && !stop;
            scnt_q  <= (state_q == SCROLL && !swrap) ? scnt_q + 1'b1 : '0;
            if (clear) begin
                state_q <= IDLE;
                len_q   <= '0;
                pos_q   <= '0;
            end else begin
                case (state_q)
                    IDLE, LOAD: if (wr_fire) begin
                        len_q   <= len_q + 1'b1;
                        state_q <= (wr_last || len_q == LW'(MSG_DEPTH - 1)) ? ARMED : LOAD;
                    end
                    ARMED: if (start && len_q != '0) begin
                        state_q <= SCROLL;
                        pos_q   <= '0;
                    end
                    SCROLL: if (stop) state_q <= ARMED;
                        else if (pass_end)
`ifdef SCROLL_LOOP_EN
                            pos_q <= '0;
`else
                            state_q <= ARMED;
`endif
                        else if (swrap) pos_q <= pos_q + 1'b1;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end
endmodule
